vga_pixel_pipe: RTL and testbench

Pixel-generation stage sitting directly downstream of the VGA timing controller. Consumes the controller's `x`, `y`, `hsync`, `vsync` and owns a 160×120, 4-bit-per-pixel framebuffer scaled 4× to 640×480. Emits registered 12-bit RGB plus sync delayed to match. A write port with valid/ready handshake lets the MCU-interface logic update the framebuffer; it is granted the single RAM port whenever the display does not need it.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/fb_ram.sv | 32 +++
 rtl/vga_pixel_pipe.sv | 141 ++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, types and the fixed colour palette for the
// VGA pixel pipeline.
//   HACTIVE/VACTIVE : visible resolution (640x480)
//   FB_W/FB_H       : framebuffer resolution (160x120, 4x scaled)
//   FB_DEPTH        : framebuffer entries (19200)
//   pix_idx_t       : 4-bit palette index
//   rgb_t           : 12-bit colour, 4 bits per channel
//   fb_addr_t       : 15-bit linear framebuffer address
//   PALETTE         : CGA 16-colour table
//   fb_addr()       : row*160+col using shift-add
package vga_pkg;

    localparam logic [9:0] HACTIVE = 10'd640;
    localparam logic [9:0] VACTIVE = 10'd480;
    localparam logic [7:0] FB_W    = 8'd160;
    localparam logic [6:0] FB_H    = 7'd120;

    typedef logic [3:0]  pix_idx_t;
    typedef logic [14:0] fb_addr_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam fb_addr_t FB_DEPTH = 15'd19200;

    localparam rgb_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    // row*160 = (row<<7)+(row<<5); 119*160+159 fits in 15 bits.
    function automatic fb_addr_t fb_addr(input logic [7:0] row, input logic [7:0] col);
        fb_addr_t row_w;
        row_w = {7'd0, row};
        return (row_w << 7) + (row_w << 5) + {7'd0, col};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram: single-port 19200x4 framebuffer with synchronous read.
//   clk  : clock
//   we   : write enable (a cycle with we high does not update dout)
//   addr : read or write address
//   din  : write data
//   dout : registered read data, valid the cycle after addr
// Contents are not reset.
module fb_ram
    import vga_pkg::*;
(
    input  logic     clk,
    input  logic     we,
    input  fb_addr_t addr,
    input  pix_idx_t din,
    output pix_idx_t dout
);

    pix_idx_t mem [FB_DEPTH];
    pix_idx_t dout_q;

    // Single RAM port: write when enabled, otherwise read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end else begin
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: turns timing-controller coordinates into registered 12-bit
// RGB from a 4x-scaled 160x120 palette-indexed framebuffer, with syncs delayed
// to match (2-cycle latency). The framebuffer write port shares the single
// RAM port and is granted whenever the display is not fetching.
// Ports:
//   vgaclk, reset_n        : pixel clock, async active-low reset
//   testpat                : (only with VGA_TESTPAT_EN) show 10 vertical bars
//   x, y                   : current column/row
//   hsync_in, vsync_in     : active-low syncs from the controller
//   wr_valid/wr_ready      : write handshake; wr_addr/wr_data payload
//   r, g, b                : registered colour
//   hsync, vsync           : registered syncs aligned to colour
// Optional feature macro: VGA_TESTPAT_EN
module vga_pixel_pipe #(
    parameter logic [9:0] HACTIVE = vga_pkg::HACTIVE,
    parameter logic [9:0] VACTIVE = vga_pkg::VACTIVE
) (
    input  logic        vgaclk,
    input  logic        reset_n,
`ifdef VGA_TESTPAT_EN
    input  logic        testpat,
`endif
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [3:0]  wr_data,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hsync,
    output logic        vsync
);

    import vga_pkg::*;

    logic     active_s, rd_req_s, tp_s, ram_we_s;
    fb_addr_t ram_addr_s;
    pix_idx_t ram_dout_s, idx_s;

    logic     rd_d1_d, rd_d1_q, active_d1_d, active_d1_q;
    logic     hsync_d1_d, hsync_d1_q, vsync_d1_d, vsync_d1_q;
    logic     tp_d1_d, tp_d1_q;
    pix_idx_t tp_idx_d1_d, tp_idx_d1_q, hold_d, hold_q;
    rgb_t     rgb_d, rgb_q;
    logic     hsync_d, hsync_q, vsync_d, vsync_q;

    // Region decode, read request and RAM port arbitration
    always_comb begin
        active_s = (x < HACTIVE) && (y < VACTIVE);
`ifdef VGA_TESTPAT_EN
        tp_s = testpat;
`else
        tp_s = 1'b0;
`endif
        // One fetch per 4-pixel group; the test pattern needs no RAM.
        rd_req_s = active_s && (x[1:0] == 2'b00) && !tp_s;
        wr_ready = !rd_req_s;
        // Out-of-range writes complete the handshake but never reach the RAM.
        ram_we_s = wr_valid && !rd_req_s && (wr_addr < FB_DEPTH);
        if (rd_req_s) begin
            ram_addr_s = fb_addr(y[9:2], x[9:2]);
        end else begin
            ram_addr_s = wr_addr;
        end
    end

    fb_ram u_fb_ram (
        .clk  (vgaclk),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .din  (wr_data),
        .dout (ram_dout_s)
    );

    // Stage-1 next values: request, region, syncs and test-pattern index
    always_comb begin
        rd_d1_d     = rd_req_s;
        active_d1_d = active_s;
        hsync_d1_d  = hsync_in;
        vsync_d1_d  = vsync_in;
        tp_d1_d     = tp_s && active_s;
        tp_idx_d1_d = x[9:6];
    end

    // Index select and stage-2 next values (blanking forced black)
    always_comb begin
        if (tp_d1_q) begin
            idx_s = tp_idx_d1_q;
        end else if (rd_d1_q) begin
            idx_s = ram_dout_s;
        end else begin
            idx_s = hold_q;
        end
        hold_d = idx_s;
        if (active_d1_q) begin
            rgb_d = PALETTE[idx_s];
        end else begin
            rgb_d = rgb_t'(12'h000);
        end
        hsync_d = hsync_d1_q;
        vsync_d = vsync_d1_q;
    end

    // Pipeline registers, async reset to black with syncs inactive
    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_d1_q     <= 1'b0;
            active_d1_q <= 1'b0;
            hsync_d1_q  <= 1'b1;
            vsync_d1_q  <= 1'b1;
            tp_d1_q     <= 1'b0;
            tp_idx_d1_q <= 4'd0;
            hold_q      <= 4'd0;
            rgb_q       <= rgb_t'(12'h000);
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            rd_d1_q     <= rd_d1_d;
            active_d1_q <= active_d1_d;
            hsync_d1_q  <= hsync_d1_d;
            vsync_d1_q  <= vsync_d1_d;
            tp_d1_q     <= tp_d1_d;
            tp_idx_d1_q <= tp_idx_d1_d;
            hold_q      <= hold_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign r     = rgb_q.r;
    assign g     = rgb_q.g;
    assign b     = rgb_q.b;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: randomized stimulus against a
// framebuffer/palette reference model with a 2-deep expected-output queue.
module tb_vga_pixel_pipe;

    logic        vgaclk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        hsync_in, vsync_in, wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [3:0]  wr_data, r, g, b;
    logic        hsync, vsync;
`ifdef VGA_TESTPAT_EN
    logic        testpat;
`endif

    vga_pixel_pipe dut (
        .vgaclk   (vgaclk),
        .reset_n  (reset_n),
`ifdef VGA_TESTPAT_EN
        .testpat  (testpat),
`endif
        .x        (x),
        .y        (y),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .r        (r),
        .g        (g),
        .b        (b),
        .hsync    (hsync),
        .vsync    (vsync)
    );

    always #5 vgaclk = ~vgaclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] pal [16];
    logic [3:0]  fb [19200];
    logic [3:0]  fetched;   // index fetched at the last 4-aligned active column

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        has_const;
        logic [11:0] cval;
        int          px;
        int          py;
    } exp_t;
    exp_t q[$];

    // One pixel clock: drive inputs, check wr_ready, queue expectation,
    // update model RAM, compare output of the transaction two steps back.
    task automatic step(input int sx, input int sy, input logic shs, input logic svs,
                        input logic swv, input int sa, input logic [3:0] sd,
                        input logic cc, input logic [11:0] cv, output logic rdy_o);
        exp_t e;
        logic act, rd, exp_rdy;
        logic [3:0] idx;
        logic [11:0] got;
        x = 10'(sx); y = 10'(sy); hsync_in = shs; vsync_in = svs;
        wr_valid = swv; wr_addr = 15'(sa); wr_data = sd;
        act = (sx < 640) && (sy < 480);
        rd  = act && (sx % 4 == 0);
`ifdef VGA_TESTPAT_EN
        if (testpat) rd = 1'b0;
`endif
        exp_rdy = !rd;
        if (rd) fetched = fb[(sy / 4) * 160 + (sx / 4)];
        idx = fetched;
`ifdef VGA_TESTPAT_EN
        if (testpat && act) idx = 4'(sx / 64);
`endif
        #1;
        rdy_o = wr_ready;
        n_cmp++;
        if (wr_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL wr_ready x=%0d y=%0d got %b want %b", sx, sy, wr_ready, exp_rdy);
        end
        e.rgb = act ? pal[idx] : 12'h000;
        e.hs = shs; e.vs = svs; e.has_const = cc; e.cval = cv; e.px = sx; e.py = sy;
        q.push_back(e);
        @(posedge vgaclk);
        if (swv && exp_rdy && sa < 19200) fb[sa] = sd;
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            got = {r, g, b};
            n_cmp++;
            if ({got, hsync, vsync} !== {e.rgb, e.hs, e.vs}) begin
                n_bad++;
                $display("FAIL pixel x=%0d y=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                         e.px, e.py, got, hsync, vsync, e.rgb, e.hs, e.vs);
            end
            if (e.has_const) begin
                n_cmp++;
                if (got !== e.cval) begin
                    n_bad++;
                    $display("FAIL fixed_colour x=%0d y=%0d got %h want %h", e.px, e.py, got, e.cval);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if ({r, g, b, hsync, vsync} !== {12'h000, 2'b11}) begin
            n_bad++;
            $display("FAIL %s got rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1", tag, {r, g, b}, hsync, vsync);
        end
    endtask

    task automatic test_reset();
        logic rdy;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 10'($urandom_range(0, 799)); y = 10'($urandom_range(0, 524));
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            wr_valid = 1'($urandom); wr_addr = 15'($urandom); wr_data = 4'($urandom);
            @(posedge vgaclk); #1;
            check_reset_outputs("reset_hold");
        end
        reset_n = 1'b1;
        q.delete(); fetched = 4'd0;
        // blanking with random syncs: exercises the 2-cycle sync delay
        for (int i = 0; i < 20; i++)
            step(700, $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'b0, 0, 4'd0, 1'b0, 12'h000, rdy);
    endtask

    task automatic test_fill();
        logic rdy;
        for (int a = 0; a < 19200; a++)
            step($urandom_range(640, 799), $urandom_range(0, 524), 1'($urandom), 1'b1,
                 1'b1, a, 4'($urandom), 1'b0, 12'h000, rdy);
    endtask

    task automatic test_write_blank();
        logic rdy;
        step(700, 10, 1'b1, 1'b1, 1'b1, 161, 4'hA, 1'b0, 12'h000, rdy);
        for (int yy = 0; yy < 9; yy++)
            for (int xx = 0; xx < 660; xx++)
                step(xx, yy, 1'b1, 1'b1, 1'b0, 0, 4'd0,
                     (xx >= 4 && xx <= 7 && yy >= 4 && yy <= 7), 12'h5F5, rdy);
    endtask

    task automatic test_write_stall();
        logic rdy;
        int stall_run;
        for (int l = 0; l < 3; l++) begin
            int yy;
            yy = $urandom_range(0, 479);
            stall_run = 0;
            for (int xx = 0; xx < 640; xx++) begin
                step(xx, yy, 1'b1, 1'b1, 1'b1, $urandom_range(0, 19199), 4'($urandom),
                     1'b0, 12'h000, rdy);
                stall_run = rdy ? 0 : stall_run + 1;
                n_cmp++;
                if (stall_run > 1) begin
                    n_bad++;
                    $display("FAIL stall_bound x=%0d y=%0d got %0d stalled cycles want <=1", xx, yy, stall_run);
                end
            end
        end
    endtask

    task automatic test_oob_write();
        logic rdy;
        step(700, 500, 1'b1, 1'b1, 1'b1, 19200, 4'hF, 1'b0, 12'h000, rdy);
        step(700, 500, 1'b1, 1'b1, 1'b1, 32767, 4'hF, 1'b0, 12'h000, rdy);
        // Random-access readback: every 4-aligned position fetches one entry
        for (int rr = 0; rr < 120; rr++)
            for (int cc = 0; cc < 160; cc++)
                step(cc * 4, rr * 4, 1'b1, 1'b1, 1'b0, 0, 4'd0, 1'b0, 12'h000, rdy);
    endtask

    task automatic test_sync_align();
        logic rdy;
        for (int a = 800; a < 960; a++)
            step(720, 490, 1'b1, 1'b1, 1'b1, a, 4'hF, 1'b0, 12'h000, rdy);
        for (int xx = 0; xx < 800; xx++)
            step(xx, 20, !(xx >= 656 && xx < 752), 1'b1, 1'b0, 0, 4'd0,
                 1'b1, (xx < 640) ? 12'hFFF : 12'h000, rdy);
    endtask

    task automatic test_async_reset();
        logic rdy;
        for (int xx = 0; xx < 16; xx++)
            step(xx, 21, 1'b0, 1'b0, 1'b0, 0, 4'd0, 1'b1, 12'hFFF, rdy);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset_now");
        @(posedge vgaclk); #1;
        check_reset_outputs("async_reset_held");
        reset_n = 1'b1;
        q.delete(); fetched = 4'd0;
        for (int xx = 0; xx < 40; xx++)
            step(xx, 22, 1'b1, 1'b1, 1'b0, 0, 4'd0, 1'b1, 12'hFFF, rdy);
    endtask

`ifdef VGA_TESTPAT_EN
    task automatic test_testpat();
        logic rdy;
        testpat = 1'b1;
        for (int xx = 0; xx < 650; xx++)
            step(xx, 100, 1'b1, 1'b1, 1'b1, $urandom_range(0, 19199), 4'($urandom),
                 (xx < 64) || (xx >= 256 && xx < 320), (xx < 64) ? 12'h000 : 12'hA00, rdy);
        testpat = 1'b0;
        step(700, 500, 1'b1, 1'b1, 1'b0, 0, 4'd0, 1'b0, 12'h000, rdy);
    endtask
`endif

    initial begin
        logic rdy;
        pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
        reset_n = 1'b0;
        x = 10'd0; y = 10'd0; hsync_in = 1'b1; vsync_in = 1'b1;
        wr_valid = 1'b0; wr_addr = 15'd0; wr_data = 4'd0;
`ifdef VGA_TESTPAT_EN
        testpat = 1'b0;
`endif
        fetched = 4'd0;
        test_reset();
        test_fill();
        test_write_blank();
        test_write_stall();
        test_oob_write();
        test_sync_align();
        test_async_reset();
`ifdef VGA_TESTPAT_EN
        test_testpat();
`endif
        // drain the pipeline
        step(700, 500, 1'b1, 1'b1, 1'b0, 0, 4'd0, 1'b0, 12'h000, rdy);
        step(700, 500, 1'b1, 1'b1, 1'b0, 0, 4'd0, 1'b0, 12'h000, rdy);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
